// File: rtl/riscv_dbg_pkg.sv
// rtl/riscv_dbg_pkg.sv - debug controller state encoding and register-file defaults
package riscv_dbg_pkg;

    localparam int DBG_XLEN = 32;
    localparam int DBG_NREG = 32;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        HALTED,
        ACCESS,
        STEP
    } dbg_state_t;

endpackage

// File: rtl/dbg_ctrl.sv
// rtl/dbg_ctrl.sv - halt/step/resume control and debug register-file access
// Stops fetch, drains the pipeline, then serves one register request every two cycles.
module dbg_ctrl
    import riscv_dbg_pkg::*;
#(
    parameter int XLEN          = DBG_XLEN,
    parameter int NREG          = DBG_NREG,
    parameter int AW            = $clog2(NREG),
    parameter int DRAIN_CYCLES  = 5,
    parameter int HALT_ON_RESET = 0
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            hz,
    input  logic            dbg_halt_req,
    input  logic            dbg_resume_req,
    input  logic            dbg_step_req,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic            dbg_req_we,
    input  logic [AW-1:0]   dbg_req_addr,
    input  logic [XLEN-1:0] dbg_req_wdata,
    output logic            dbg_rsp_valid,
    output logic [XLEN-1:0] dbg_rsp_rdata,
    output logic            dbg_rsp_err,
    output logic            dbg_halted,
    output logic            fetch_en,
    output logic            rf_dbg_sel,
    output logic [AW-1:0]   rf_dbg_addr,
    output logic            rf_dbg_we,
    output logic [XLEN-1:0] rf_dbg_wdata,
    input  logic [XLEN-1:0] rf_rdata
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam dbg_state_t RST_STATE = (HALT_ON_RESET != 0) ? HALTED : RUN;

    dbg_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic            rf_we_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic req_in_range;
    logic addr_q_in_range;

    // AW may be wider than needed to index NREG, so range checks are done at 32 bits.
    assign req_in_range    = (32'(dbg_req_addr) < 32'(NREG));
    assign addr_q_in_range = (32'(addr_q) < 32'(NREG));

    assign fetch_en      = (state_q == RUN) || (state_q == STEP);
    assign dbg_halted    = (state_q == HALTED) || (state_q == ACCESS);
    assign dbg_req_ready = (state_q == HALTED);
    assign rf_dbg_sel    = dbg_halted;
    assign rf_dbg_addr   = ((state_q == ACCESS) && addr_q_in_range) ? addr_q : '0;
    assign rf_dbg_we     = rf_we_q;
    assign rf_dbg_wdata  = wdata_q;
    assign dbg_rsp_valid = rsp_valid_q;
    assign dbg_rsp_rdata = rsp_rdata_q;
    assign dbg_rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rf_we_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            case (state_q)
                RUN: begin
                    if (dbg_halt_req) begin
                        state_q <= DRAIN;
                        cnt_q   <= CW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= HALTED;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HALTED: begin
                    if (dbg_req_valid) begin
                        state_q <= ACCESS;
                        addr_q  <= dbg_req_addr;
                        we_q    <= dbg_req_we;
                        wdata_q <= dbg_req_wdata;
                        // x0 is hardwired zero, so its writes never reach the register file.
                        rf_we_q <= dbg_req_we && req_in_range && (|dbg_req_addr);
                    end else if (dbg_step_req) begin
                        state_q <= STEP;
                    end else if (dbg_resume_req && !dbg_halt_req) begin
                        state_q <= RUN;
                    end
                end
                ACCESS: begin
                    state_q     <= HALTED;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= !addr_q_in_range;
                    rsp_rdata_q <= (!we_q && addr_q_in_range && (|addr_q)) ? rf_rdata : '0;
                end
                STEP: begin
                    if (!hz) begin
                        state_q <= DRAIN;
                        cnt_q   <= CW'(DRAIN_CYCLES - 1);
                    end
                end
                default: state_q <= RST_STATE;
            endcase
        end
    end

endmodule
